// File: rtl/alu_decode_stage_if.sv
// Bundle of handshake, decoded-output and multdiv signals for alu_decode_stage.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface alu_decode_stage_if;
    logic        in_valid;
    logic [31:0] instr_in;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_ctrl;
    logic [4:0]  shamt;
    logic        is_add;
    logic        is_addi;
    logic        is_sub;
    logic        is_mul;
    logic        is_div;
    logic [2:0]  rstatus_code;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic        md_result_rdy;
    logic        md_exception;
    logic        md_exc_out;
    logic        md_timeout;

    modport master (
        output in_valid, instr_in, out_ready, md_result_rdy, md_exception,
        input  in_ready, out_valid, alu_ctrl, shamt, is_add, is_addi, is_sub,
               is_mul, is_div, rstatus_code, md_ctrl_mult, md_ctrl_div,
               md_exc_out, md_timeout
    );

    modport slave (
        input  in_valid, instr_in, out_ready, md_result_rdy, md_exception,
        output in_ready, out_valid, alu_ctrl, shamt, is_add, is_addi, is_sub,
               is_mul, is_div, rstatus_code, md_ctrl_mult, md_ctrl_div,
               md_exc_out, md_timeout
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage with valid/ready handshake; mul/div instructions
// launch the multdiv unit and stall until it answers or the BUSY counter times out.
module alu_decode_stage #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input logic               clock,
    input logic               reset,
    alu_decode_stage_if.slave bus
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic       unused_instr_bits;

    logic [4:0] dec_alu;
    logic       dec_add;
    logic       dec_addi;
    logic       dec_sub;
    logic       dec_mul;
    logic       dec_div;
    logic [2:0] dec_code;
    logic       dec_md;

    logic       in_ready_c;
    logic       out_valid_c;
    logic       load;

    logic [CNT_W-1:0] cnt;
    logic [4:0]       alu_ctrl_q;
    logic [4:0]       shamt_q;
    logic             is_add_q;
    logic             is_addi_q;
    logic             is_sub_q;
    logic             is_mul_q;
    logic             is_div_q;
    logic [2:0]       rstatus_q;
    logic             md_mult_q;
    logic             md_div_q;
    logic             md_exc_q;
    logic             md_timeout_q;

    assign opcode            = bus.instr_in[31:27];
    assign alu_op            = bus.instr_in[6:2];
    assign unused_instr_bits = ^{bus.instr_in[26:12], bus.instr_in[1:0]};

    // Decode of the presented word; it only ever feeds registers, never an output.
    always_comb begin
        dec_alu  = 5'b00000;
        dec_add  = 1'b0;
        dec_addi = 1'b0;
        dec_sub  = 1'b0;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_code = 3'd0;
        case (opcode)
            OP_RTYPE: begin
                case (alu_op)
                    5'b00000: begin dec_add = 1'b1; dec_code = 3'd1; end
                    5'b00001: begin dec_alu = 5'b00001; dec_sub = 1'b1; dec_code = 3'd3; end
                    5'b00010: dec_alu = 5'b00010;
                    5'b00011: dec_alu = 5'b00011;
                    5'b00100: dec_alu = 5'b00100;
                    5'b00101: dec_alu = 5'b00101;
                    5'b00110: begin dec_alu = 5'b00110; dec_mul = 1'b1; dec_code = 3'd4; end
                    5'b00111: begin dec_alu = 5'b00111; dec_div = 1'b1; dec_code = 3'd5; end
                    default:  dec_alu = 5'b00000;
                endcase
            end
            OP_ADDI: begin dec_addi = 1'b1; dec_code = 3'd2; end
            OP_SW:   dec_alu = 5'b00000;
            OP_LW:   dec_alu = 5'b00000;
            default: dec_alu = 5'b00000;
        endcase
    end

    assign dec_md = dec_mul | dec_div;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake; in_ready never looks at in_valid or the instruction.
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            EMPTY: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    next_state = dec_md ? BUSY : FULL;
                end
            end
            FULL: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        next_state = dec_md ? BUSY : FULL;
                    end else begin
                        next_state = EMPTY;
                    end
                end
            end
            BUSY: begin
                if (bus.md_result_rdy || (cnt == CNT_LAST)) begin
                    next_state = FULL;
                end
            end
            default: next_state = EMPTY;
        endcase
        if (reset) begin
            in_ready_c  = 1'b0;
            out_valid_c = 1'b0;
        end
    end

    assign load = in_ready_c & bus.in_valid;

    // Held decode plus multdiv bookkeeping; a result in the final BUSY cycle beats the timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            alu_ctrl_q   <= 5'b00000;
            shamt_q      <= 5'b00000;
            is_add_q     <= 1'b0;
            is_addi_q    <= 1'b0;
            is_sub_q     <= 1'b0;
            is_mul_q     <= 1'b0;
            is_div_q     <= 1'b0;
            rstatus_q    <= 3'd0;
            md_mult_q    <= 1'b0;
            md_div_q     <= 1'b0;
            md_exc_q     <= 1'b0;
            md_timeout_q <= 1'b0;
        end else begin
            md_mult_q <= 1'b0;
            md_div_q  <= 1'b0;
            if (load) begin
                alu_ctrl_q   <= dec_alu;
                shamt_q      <= bus.instr_in[11:7];
                is_add_q     <= dec_add;
                is_addi_q    <= dec_addi;
                is_sub_q     <= dec_sub;
                is_mul_q     <= dec_mul;
                is_div_q     <= dec_div;
                rstatus_q    <= dec_code;
                md_mult_q    <= dec_mul;
                md_div_q     <= dec_div;
                md_exc_q     <= 1'b0;
                md_timeout_q <= 1'b0;
                cnt          <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_ONE;
                if (bus.md_result_rdy) begin
                    md_exc_q     <= bus.md_exception;
                    md_timeout_q <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    md_exc_q     <= 1'b0;
                    md_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.alu_ctrl     = alu_ctrl_q;
    assign bus.shamt        = shamt_q;
    assign bus.is_add       = is_add_q;
    assign bus.is_addi      = is_addi_q;
    assign bus.is_sub       = is_sub_q;
    assign bus.is_mul       = is_mul_q;
    assign bus.is_div       = is_div_q;
    assign bus.rstatus_code = rstatus_q;
    assign bus.md_ctrl_mult = md_mult_q;
    assign bus.md_ctrl_div  = md_div_q;
    assign bus.md_exc_out   = md_exc_q;
    assign bus.md_timeout   = md_timeout_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: handshake, decode table, multdiv stall,
// timeout and reset-abort behaviour, with hand-computed expectations.
module tb_alu_decode_stage;

    localparam logic [31:0] I_ADD  = 32'h0000_0000;
    localparam logic [31:0] I_SRA3 = 32'h0000_0194;
    localparam logic [31:0] I_ADDI = 32'h2800_0000;
    localparam logic [31:0] I_SUB  = 32'h0000_0004;
    localparam logic [31:0] I_OR   = 32'h0000_000C;
    localparam logic [31:0] I_MUL  = 32'h0000_0018;
    localparam logic [31:0] I_DIV  = 32'h0000_001C;
    localparam logic [31:0] I_BADO = 32'hF800_0000;
    localparam logic [31:0] I_BADA = 32'h0000_0020;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    alu_decode_stage_if bus ();

    alu_decode_stage #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.instr_in      = I_ADD;
        bus.out_ready     = 1'b0;
        bus.md_result_rdy = 1'b0;
        bus.md_exception  = 1'b0;
        next_cycle();
        next_cycle();
        #2;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.alu_ctrl !== 5'd0) begin failures++; $display("FAIL rst_alu got=%0h exp=0", bus.alu_ctrl); end
        checks++; if (bus.rstatus_code !== 3'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", bus.rstatus_code); end
        checks++; if (bus.md_timeout !== 1'b0) begin failures++; $display("FAIL rst_md_timeout got=%0b exp=0", bus.md_timeout); end
        next_cycle();
        reset = 1'b0;
        #2;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_release_out_valid got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_add_sra;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = I_ADD;
        next_cycle();
        bus.in_valid = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.alu_ctrl !== 5'b00000) begin failures++; $display("FAIL add_alu got=%0h exp=0", bus.alu_ctrl); end
        checks++; if (bus.is_add !== 1'b1) begin failures++; $display("FAIL add_flag got=%0b exp=1", bus.is_add); end
        checks++; if (bus.rstatus_code !== 3'd1) begin failures++; $display("FAIL add_code got=%0d exp=1", bus.rstatus_code); end
        bus.in_valid = 1'b1;
        bus.instr_in = I_SRA3;
        next_cycle();
        bus.in_valid = 1'b0;
        #2;
        checks++; if (bus.alu_ctrl !== 5'b00101) begin failures++; $display("FAIL sra_alu got=%0h exp=5", bus.alu_ctrl); end
        checks++; if (bus.shamt !== 5'd3) begin failures++; $display("FAIL sra_shamt got=%0d exp=3", bus.shamt); end
        checks++; if (bus.is_add !== 1'b0 || bus.rstatus_code !== 3'd0) begin failures++; $display("FAIL sra_flags got=%0b/%0d exp=0/0", bus.is_add, bus.rstatus_code); end
        next_cycle();
        #2;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL sra_drain got=%0b/%0b exp=0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_back_to_back;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = I_ADDI;
        next_cycle();
        bus.instr_in = I_SUB;
        #2;
        checks++; if (bus.alu_ctrl !== 5'd0 || bus.is_addi !== 1'b1 || bus.rstatus_code !== 3'd2) begin
            failures++; $display("FAIL addi_out got=%0h/%0b/%0d exp=0/1/2", bus.alu_ctrl, bus.is_addi, bus.rstatus_code); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL addi_in_ready got=%0b exp=1", bus.in_ready); end
        next_cycle();
        bus.instr_in  = I_OR;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) next_cycle();
            #2;
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'b00001 || bus.rstatus_code !== 3'd3 || bus.is_sub !== 1'b1) begin
                failures++; $display("FAIL stall_sub[%0d] got=%0b/%0h/%0d exp=1/1/3", i, bus.out_valid, bus.alu_ctrl, bus.rstatus_code); end
        end
        next_cycle();
        bus.out_ready = 1'b1;
        #2;
        checks++; if (bus.in_ready !== 1'b1 || bus.alu_ctrl !== 5'b00001) begin
            failures++; $display("FAIL release_sub got=%0b/%0h exp=1/1", bus.in_ready, bus.alu_ctrl); end
        next_cycle();
        bus.in_valid = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'b00011 || bus.rstatus_code !== 3'd0 || bus.is_sub !== 1'b0) begin
            failures++; $display("FAIL or_out got=%0b/%0h/%0d exp=1/3/0", bus.out_valid, bus.alu_ctrl, bus.rstatus_code); end
        next_cycle();
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL or_single got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_mul;
        int pulses    = 0;
        int div_pulse = 0;
        int first_k   = 0;
        int busy_bad  = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = I_MUL;
        for (int k = 1; k <= 17; k++) begin
            next_cycle();
            bus.in_valid      = 1'b0;
            bus.md_result_rdy = (k == 17);
            bus.md_exception  = (k == 17);
            #2;
            if (bus.md_ctrl_mult === 1'b1) begin pulses++; if (first_k == 0) first_k = k; end
            if (bus.md_ctrl_div !== 1'b0) div_pulse++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_bad++;
        end
        next_cycle();
        bus.md_result_rdy = 1'b0;
        bus.md_exception  = 1'b0;
        #2;
        checks++; if (pulses != 1 || first_k != 1) begin failures++; $display("FAIL mul_pulse got=%0d@%0d exp=1@1", pulses, first_k); end
        checks++; if (div_pulse != 0) begin failures++; $display("FAIL mul_div_pulse got=%0d exp=0", div_pulse); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL mul_busy_handshake got=%0d exp=0", busy_bad); end
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'b00110 || bus.is_mul !== 1'b1 || bus.rstatus_code !== 3'd4) begin
            failures++; $display("FAIL mul_out got=%0b/%0h/%0b/%0d exp=1/6/1/4", bus.out_valid, bus.alu_ctrl, bus.is_mul, bus.rstatus_code); end
        checks++; if (bus.md_exc_out !== 1'b1 || bus.md_timeout !== 1'b0) begin
            failures++; $display("FAIL mul_exc got=%0b/%0b exp=1/0", bus.md_exc_out, bus.md_timeout); end
        next_cycle();
        #2;
    endtask

    task automatic test_div_timeout(input logic rdy_on_last);
        int pulses   = 0;
        int busy_bad = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = I_DIV;
        for (int k = 1; k <= 40; k++) begin
            next_cycle();
            bus.in_valid      = 1'b0;
            bus.md_result_rdy = rdy_on_last && (k == 40);
            bus.md_exception  = rdy_on_last && (k == 40);
            #2;
            if (bus.md_ctrl_div === 1'b1) pulses++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) busy_bad++;
        end
        next_cycle();
        bus.md_result_rdy = 1'b0;
        bus.md_exception  = 1'b0;
        #2;
        checks++; if (pulses != 1) begin failures++; $display("FAIL div_pulse[%0b] got=%0d exp=1", rdy_on_last, pulses); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL div_busy[%0b] got=%0d exp=0", rdy_on_last, busy_bad); end
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'b00111 || bus.is_div !== 1'b1 || bus.rstatus_code !== 3'd5) begin
            failures++; $display("FAIL div_out[%0b] got=%0b/%0h/%0d exp=1/7/5", rdy_on_last, bus.out_valid, bus.alu_ctrl, bus.rstatus_code); end
        checks++; if (bus.md_timeout !== !rdy_on_last || bus.md_exc_out !== rdy_on_last) begin
            failures++; $display("FAIL div_timeout[%0b] got=%0b/%0b exp=%0b/%0b", rdy_on_last, bus.md_timeout, bus.md_exc_out, !rdy_on_last, rdy_on_last); end
        next_cycle();
        #2;
    endtask

    task automatic test_reset_busy;
        int stray = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = I_DIV;
        next_cycle();
        bus.in_valid = 1'b0;
        repeat (4) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL abort_state got=%0b/%0b exp=1/0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.alu_ctrl !== 5'd0 || bus.is_div !== 1'b0 || bus.rstatus_code !== 3'd0 || bus.md_ctrl_div !== 1'b0 || bus.md_timeout !== 1'b0) begin
            failures++; $display("FAIL abort_outputs got=%0h/%0b/%0d/%0b/%0b exp=0/0/0/0/0", bus.alu_ctrl, bus.is_div, bus.rstatus_code, bus.md_ctrl_div, bus.md_timeout); end
        bus.md_result_rdy = 1'b1;
        bus.md_exception  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            bus.md_result_rdy = 1'b0;
            bus.md_exception  = 1'b0;
            #2;
            if (bus.out_valid !== 1'b0 || bus.md_ctrl_div !== 1'b0 || bus.md_exc_out !== 1'b0 || bus.in_ready !== 1'b1) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL abort_ignore_rdy got=%0d exp=0", stray); end
    endtask

    task automatic test_unknown;
        int md_seen = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = I_SUB;
        next_cycle();
        bus.instr_in = I_BADO;
        next_cycle();
        bus.instr_in = I_BADA;
        #2;
        if (bus.md_ctrl_mult !== 1'b0 || bus.md_ctrl_div !== 1'b0) md_seen++;
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd0 || bus.rstatus_code !== 3'd0 || bus.is_sub !== 1'b0) begin
            failures++; $display("FAIL bad_opcode got=%0b/%0h/%0d/%0b exp=1/0/0/0", bus.out_valid, bus.alu_ctrl, bus.rstatus_code, bus.is_sub); end
        next_cycle();
        bus.in_valid = 1'b0;
        #2;
        if (bus.md_ctrl_mult !== 1'b0 || bus.md_ctrl_div !== 1'b0) md_seen++;
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd0 || bus.rstatus_code !== 3'd0 ||
                      {bus.is_add, bus.is_addi, bus.is_sub, bus.is_mul, bus.is_div} !== 5'b0) begin
            failures++; $display("FAIL bad_aluop got=%0b/%0h/%0d exp=1/0/0", bus.out_valid, bus.alu_ctrl, bus.rstatus_code); end
        next_cycle();
        #2;
        checks++; if (md_seen != 0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL bad_md_pulse got=%0d/%0b exp=0/0", md_seen, bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_sra();
        test_back_to_back();
        test_mul();
        test_div_timeout(1'b0);
        test_div_timeout(1'b1);
        test_reset_busy();
        test_unknown();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered, handshaked successor to the combinational ALU decoder in the CPU decode path. Accepts one 32-bit instruction per cycle through a valid/ready interface and emits registered ALU control, shift amount, instruction-class flags and an rstatus code. For `mul`/`div` it launches the multdiv unit, then holds the pipeline until the unit reports a result or a programmable timeout expires.

## Interface
- `MD_TIMEOUT`, default 40: number of BUSY cycles after which an unfinished mul/div is abandoned. Legal range 2..2^CNT_W-1.
- `CNT_W`, default 6: width of the BUSY cycle counter.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `instr_in` is presented.
- `instr_in`  in  32  instruction word.
- `in_ready`  out  1  the stage accepts `instr_in` this cycle.
- `out_valid`  out  1  decoded outputs are valid.
- `out_ready`  in  1  downstream consumes the outputs this cycle.
- `alu_ctrl`  out  5  ALU opcode.
- `shamt`  out  5  `instr[11:7]` of the held instruction.
- `is_add`, `is_addi`, `is_sub`, `is_mul`, `is_div`  out  1 each  class flags of the held instruction.
- `rstatus_code`  out  3  add=1, addi=2, sub=3, mul=4, div=5, else 0.
- `md_ctrl_mult`, `md_ctrl_div`  out  1 each  one-cycle start pulses to multdiv.
- `md_result_rdy`  in  1  multdiv result ready.
- `md_exception`  in  1  multdiv exception, sampled together with `md_result_rdy`.
- `md_exc_out`  out  1  captured exception for the held mul/div.
- `md_timeout`  out  1  the held mul/div ended by timeout.

## Operation
- Opcode decode uses `instr[31:27]`: R-type=00000, addi=00101, sw=00111, lw=01000. ALU op uses `instr[6:2]` and applies only to R-type.
- `alu_ctrl` values: add, addi, sw, lw=00000; sub=00001; and=00010; or=00011; sll=00100; sra=00101; mul=00110; div=00111. Any other opcode or ALU op gives 00000 with all flags 0.
- FSM states are EMPTY, FULL and BUSY.
- EMPTY: `in_ready`=1 and `out_valid`=0.
  - On `in_valid`, latch `instr_in` and its decode.
  - If the instruction is mul/div, go to BUSY. Otherwise go to FULL.
- FULL: `out_valid`=1 and `in_ready`=`out_ready`.
  - `out_ready` & `in_valid`: load the new instruction. The next state is FULL, or BUSY if the new instruction is mul/div.
  - `out_ready` & !`in_valid`: go to EMPTY.
  - !`out_ready`: hold every output stable.
- BUSY: `in_ready`=0 and `out_valid`=0.
  - On the first BUSY cycle, assert `md_ctrl_mult` or `md_ctrl_div` for exactly one cycle and clear the counter. The counter then increments every BUSY cycle.
  - `md_result_rdy`=1: go to FULL, set `md_exc_out`=`md_exception`, and clear `md_timeout`.
  - Counter reaches `MD_TIMEOUT-1` without `md_result_rdy`: go to FULL with `md_timeout`=1 and `md_exc_out`=0.
  - If `md_result_rdy` and timeout occur in the same cycle, the result wins and `md_timeout`=0.
- `md_result_rdy` is ignored outside BUSY.
- `md_exc_out` and `md_timeout` clear whenever a new instruction loads.

## Timing
- Reset is synchronous: on any edge with `reset`=1 the state goes to EMPTY.
- All registered outputs reset to 0: `alu_ctrl`, `shamt`, flags, `rstatus_code`, md pulses, `md_exc_out`, `md_timeout`, counter.
- `in_ready`=0 and `out_valid`=0 while `reset` is high.
- Reset during BUSY aborts the operation. No further `md_ctrl_*` pulse is issued.
- Non-mul/div latency: accepted at edge N, `out_valid`=1 in cycle N+1. Throughput is one instruction per cycle when `out_ready` stays 1.
- Mul/div timing:
  - Accepted at edge N.
  - `md_ctrl_*` is high during cycle N+1 only.
  - `md_result_rdy` sampled at edge M gives `out_valid` in cycle M+1.
  - Earliest M is the edge ending cycle N+1.
- Timeout: `out_valid` rises `MD_TIMEOUT` cycles after entering BUSY.
- No combinational path from `instr_in` to any output. `in_ready` depends only on state, `out_ready` and `reset`.

## Test plan
- Reset, then `add` (0x00000000) with `out_ready`=1: `out_valid` the next cycle with `alu_ctrl`=00000, `is_add`=1, `rstatus_code`=1. Then `sra` with shamt 3 gives `alu_ctrl`=00101 and `shamt`=3.
- Back-to-back `addi`, `sub`, `or` with `out_ready` held low for 3 cycles on `sub`: `in_ready`=0 for those cycles, `sub` outputs (00001, code 3) stay stable, and no instruction is lost or duplicated.
- `mul` accepted, multdiv raises `md_result_rdy` 17 cycles later with `md_exception`=1: `md_ctrl_mult` pulses exactly once, `in_ready`=0 throughout, then `out_valid` with `alu_ctrl`=00110, `is_mul`=1, `md_exc_out`=1.
- `div` with `md_result_rdy` never asserted and `MD_TIMEOUT`=40: `out_valid` 40 cycles after BUSY entry with `md_timeout`=1. Repeat with `md_result_rdy` on the timeout cycle: `md_timeout`=0.
- `reset` asserted 5 cycles into a `div`: the next cycle is EMPTY, all outputs 0, and a later `md_result_rdy` pulse is ignored.
- Unknown opcode 11111 or ALU op 01000: `alu_ctrl`=00000, all flags and `rstatus_code`=0, no md pulse.
